// File: rtl/vga_fb_arb_pkg.sv
// Shared types and constants for the framebuffer arbiter.
package vga_fb_arb_pkg;

    // Deepest RAM read latency the return pipe is built to cover.
    localparam int MAX_MEM_LAT = 4;

    // Requester identity carried alongside each read in flight.
    localparam logic SRC_DISP = 1'b0;
    localparam logic SRC_CPU  = 1'b1;

    // Which requester owns the RAM command slot in a given cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DISP = 2'd1,
        CPU  = 2'd2
    } owner_t;

    // One return-pipe stage: is a read in flight, and who asked for it.
    typedef struct packed {
        logic valid;
        logic src;
    } tag_t;

    localparam tag_t TAG_NONE = '{valid: 1'b0, src: SRC_DISP};

endpackage

// File: rtl/vga_fb_arb_rdpipe.sv
// Read-return path: delays each command's tag until its RAM data arrives,
// then steers the data to the display or CPU return port.
// Stage 0 of the tag pipe is the arbiter's registered command (tag_in);
// this block holds the remaining MEM_LAT stages.
module vga_fb_arb_rdpipe
    import vga_fb_arb_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  tag_t              tag_in,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_readdatavalid
);

    tag_t              pipe_q [MEM_LAT];
    tag_t              pipe_d [MEM_LAT];
    tag_t              ret_tag;
    logic [DATA_W-1:0] disp_rdata_q, disp_rdata_d;
    logic              disp_rvalid_q, disp_rvalid_d;
    logic [DATA_W-1:0] avs_rdata_q, avs_rdata_d;
    logic              avs_rvalid_q, avs_rvalid_d;

    // The tag in the last stage matches the word now on mem_rdata.
    assign ret_tag = pipe_q[MEM_LAT-1];

    // Shift tags one stage per cycle and demux the returning word by source.
    always_comb begin
        // NOTE: every _d is given a value before any branch, so no path through
        // this block can leave one unassigned and infer a latch.
        pipe_d[0] = tag_in;
        for (int s = 1; s < MEM_LAT; s++) begin
            pipe_d[s] = pipe_q[s-1];
        end
        disp_rvalid_d = ret_tag.valid && (ret_tag.src == SRC_DISP);
        avs_rvalid_d  = ret_tag.valid && (ret_tag.src == SRC_CPU);
        disp_rdata_d  = disp_rvalid_d ? mem_rdata : disp_rdata_q;
        avs_rdata_d   = avs_rvalid_d  ? mem_rdata : avs_rdata_q;
    end

    // Tag stages and return registers; reset drops every read in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with <= only, so every flop samples
        // the values from before this edge regardless of statement order.
        if (!rst_n) begin
            // NOTE: the tag pipe is reset stage by stage even though it looks
            // like storage: a stale valid bit would fire a phantom rvalid.
            for (int s = 0; s < MEM_LAT; s++) begin
                pipe_q[s] <= TAG_NONE;
            end
            disp_rdata_q  <= '0;
            disp_rvalid_q <= 1'b0;
            avs_rdata_q   <= '0;
            avs_rvalid_q  <= 1'b0;
        end else begin
            pipe_q        <= pipe_d;
            disp_rdata_q  <= disp_rdata_d;
            disp_rvalid_q <= disp_rvalid_d;
            avs_rdata_q   <= avs_rdata_d;
            avs_rvalid_q  <= avs_rvalid_d;
        end
    end

    assign disp_rdata        = disp_rdata_q;
    assign disp_rvalid       = disp_rvalid_q;
    assign avs_readdata      = avs_rdata_q;
    assign avs_readdatavalid = avs_rvalid_q;

endmodule

// File: rtl/vga_fb_arbiter.sv
// Framebuffer RAM arbiter: shares one single-port RAM between display scanout
// reads and the CPU Avalon-MM slave, one command per cycle, display first.
// Optional build macro VGA_FB_ARB_STARVE_GUARD_EN: after CPU_MAX_WAIT display
// grants while the CPU waits, the next slot goes to the CPU.
module vga_fb_arbiter
    import vga_fb_arb_pkg::*;
#(
    parameter int ADDR_W       = 17,
    parameter int DATA_W       = 16,
    parameter int MEM_LAT      = 2,
    parameter int CPU_MAX_WAIT = 8
) (
    input  logic              csi_clk50,
    input  logic              csi_reset_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_rvalid,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [DATA_W-1:0] avs_writedata,
    output logic              avs_waitrequest,
    output logic [DATA_W-1:0] avs_readdata,
    output logic              avs_readdatavalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    // An out-of-range build never grants, so a bad configuration shows up
    // immediately as a stalled bus rather than as corrupted return data.
    localparam bit CFG_OK = (MEM_LAT >= 1) && (MEM_LAT <= MAX_MEM_LAT) &&
                            (CPU_MAX_WAIT >= 1) && (CPU_MAX_WAIT <= 255);

    owner_t            owner_q, owner_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              cpu_pend;
    logic              cpu_first;
    logic              arb_en;
    tag_t              issue_tag;

    assign cpu_pend = avs_read | avs_write;
    assign arb_en   = csi_reset_n && CFG_OK;

`ifdef VGA_FB_ARB_STARVE_GUARD_EN
    logic [7:0] starve_q, starve_d;

    // Count display wins while the CPU waits; force a CPU slot at the limit.
    always_comb begin
        cpu_first = (starve_q == 8'(CPU_MAX_WAIT));
        starve_d  = starve_q;
        if ((owner_d == CPU) || !cpu_pend) begin
            starve_d = '0;
        end else if (owner_d == DISP) begin
            starve_d = starve_q + 8'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge csi_clk50) begin
        if (!csi_reset_n) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    assign cpu_first = 1'b0;
`endif

    // Pick this cycle's owner and form the next RAM command from it.
    always_comb begin
        owner_d     = IDLE;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        if (arb_en) begin
            if (cpu_pend && (cpu_first || !disp_req)) begin
                owner_d = CPU;
            end else if (disp_req) begin
                owner_d = DISP;
            end
        end
        case (owner_d)
            DISP: begin
                mem_addr_d = disp_addr;
            end
            CPU: begin
                // A read+write collision performs the write; the read is dropped.
                mem_addr_d = avs_address;
                mem_we_d   = avs_write;
                if (avs_write) begin
                    mem_wdata_d = avs_writedata;
                end
            end
            default: begin
            end
        endcase
    end

    // Owner and registered RAM pins.
    always_ff @(posedge csi_clk50) begin
        if (!csi_reset_n) begin
            owner_q     <= IDLE;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            owner_q     <= owner_d;
            mem_addr_q  <= mem_addr_d;
            mem_we_q    <= mem_we_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign disp_gnt        = (owner_d == DISP);
    assign avs_waitrequest = (owner_d != CPU);
    assign mem_addr        = mem_addr_q;
    assign mem_we          = mem_we_q;
    assign mem_wdata       = mem_wdata_q;

    // The command now on the mem_* pins is tag stage 0: reads only, no writes.
    assign issue_tag.valid = (owner_q == DISP) || ((owner_q == CPU) && !mem_we_q);
    assign issue_tag.src   = (owner_q == CPU) ? SRC_CPU : SRC_DISP;

    vga_fb_arb_rdpipe #(
        .DATA_W  (DATA_W),
        .MEM_LAT (MEM_LAT)
    ) u_rdpipe (
        .clk               (csi_clk50),
        .rst_n             (csi_reset_n),
        .tag_in            (issue_tag),
        .mem_rdata         (mem_rdata),
        .disp_rdata        (disp_rdata),
        .disp_rvalid       (disp_rvalid),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid)
    );

endmodule
